// File: rtl/dump_engine.sv
// dump_engine: reads a byte-memory range and streams it out as lowercase
// hex ASCII lines ("AA: DD DD ...\r\n") over a valid/ready character link.
module dump_engine #(
  parameter int BPL = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] adr_dat,
  input  logic       read_start_set,
  input  logic       read_end_set,
  input  logic       read_stop,
  output logic       dump_running,
  output logic       mem_ren,
  output logic [7:0] mem_radr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  typedef enum logic [3:0] {
    IDLE, ADRH, ADRL, COLON, RDREQ, RDWAIT, SP, DH, DL, CR, LF
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(BPL - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] start_adr;
  logic [7:0] end_adr;
  logic [7:0] cur_adr;
  logic [7:0] rd_data;
  logic [3:0] cnt;
  logic       stop_flag;

  logic       xfer;
  logic       stop_pend;
  logic       last_byte;
  logic       dump_end;
  logic       line_end;

  // Convert a nibble to its lowercase hex ASCII character.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h57 + {4'h0, n};
  endfunction

  assign xfer      = tx_valid & tx_ready;
  // A stop arriving in the same cycle as a decision point counts immediately.
  assign stop_pend = stop_flag | read_stop;
  // ">=" rather than "==" so an end below start still stops after one byte.
  assign last_byte = (cur_adr >= end_adr);
  assign dump_end  = stop_pend | last_byte;
  assign line_end  = dump_end | (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: character states advance only on a transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (read_end_set) state_nxt = ADRH;
      ADRH:   if (xfer) state_nxt = ADRL;
      ADRL:   if (xfer) state_nxt = COLON;
      COLON:  if (xfer) state_nxt = stop_pend ? CR : RDREQ;
      RDREQ:  state_nxt = RDWAIT;
      RDWAIT: state_nxt = SP;
      SP:     if (xfer) state_nxt = DH;
      DH:     if (xfer) state_nxt = DL;
      DL:     if (xfer) state_nxt = line_end ? CR : RDREQ;
      CR:     if (xfer) state_nxt = LF;
      LF:     if (xfer) state_nxt = dump_end ? IDLE : ADRH;
      default: state_nxt = IDLE;
    endcase
  end

  // Address range, byte cursor, per-line count and sticky stop request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_adr <= 8'h00;
      end_adr   <= 8'h00;
      cur_adr   <= 8'h00;
      cnt       <= 4'h0;
      stop_flag <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (read_start_set) start_adr <= adr_dat;
        if (read_end_set) begin
          end_adr <= adr_dat;
          cur_adr <= start_adr;
          cnt     <= 4'h0;
        end
      end
      if (state == DL && xfer && !line_end) begin
        cur_adr <= cur_adr + 8'h01;
        cnt     <= cnt + 4'h1;
      end
      if (state == LF && xfer && !dump_end) begin
        cur_adr <= cur_adr + 8'h01;
        cnt     <= 4'h0;
      end
      if (state_nxt == IDLE)                 stop_flag <= 1'b0;
      else if (state != IDLE && read_stop)   stop_flag <= 1'b1;
    end
  end

  // Capture the memory byte one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (state == RDWAIT) rd_data <= mem_rdata;
  end

  // Output decode: the character presented depends only on state and held registers.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    mem_ren  = 1'b0;
    case (state)
      ADRH:  begin tx_valid = 1'b1; tx_data = hex_char(cur_adr[7:4]); end
      ADRL:  begin tx_valid = 1'b1; tx_data = hex_char(cur_adr[3:0]); end
      COLON: begin tx_valid = 1'b1; tx_data = 8'h3a; end
      RDREQ: mem_ren = 1'b1;
      SP:    begin tx_valid = 1'b1; tx_data = 8'h20; end
      DH:    begin tx_valid = 1'b1; tx_data = hex_char(rd_data[7:4]); end
      DL:    begin tx_valid = 1'b1; tx_data = hex_char(rd_data[3:0]); end
      CR:    begin tx_valid = 1'b1; tx_data = 8'h0d; end
      LF:    begin tx_valid = 1'b1; tx_data = 8'h0a; end
      default: ;
    endcase
  end

  assign dump_running = (state != IDLE);
  assign mem_radr     = cur_adr;

endmodule

// File: tb/tb_dump_engine.sv
// tb_dump_engine: randomized/directed dump scenarios checked against a
// line-formatting reference model of the hex dump output.
module tb_dump_engine;

  localparam int BPL = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] adr_dat;
  logic       read_start_set;
  logic       read_end_set;
  logic       read_stop;
  logic       dump_running;
  logic       mem_ren;
  logic [7:0] mem_radr;
  logic [7:0] mem_rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  logic [7:0] mem [256];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  dump_engine #(.BPL(BPL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .adr_dat        (adr_dat),
    .read_start_set (read_start_set),
    .read_end_set   (read_end_set),
    .read_stop      (read_stop),
    .dump_running   (dump_running),
    .mem_ren        (mem_ren),
    .mem_radr       (mem_radr),
    .mem_rdata      (mem_rdata),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_radr];
  end

  task automatic push_hex(input logic [7:0] v);
    string t;
    t = $sformatf("%02x", v);
    exp_q.push_back(t[0]);
    exp_q.push_back(t[1]);
  endtask

  // Reference model: lines of up to BPL bytes, first byte address as prefix,
  // ending at end address (or the start byte when end<start) or the stop byte.
  task automatic build_exp(input int s, input int e, input int stop_byte);
    int a;
    int n;
    exp_q.delete();
    a = s;
    n = 0;
    forever begin
      if (n == 0) begin
        push_hex(8'(a));
        exp_q.push_back(8'h3a);
      end
      exp_q.push_back(8'h20);
      push_hex(mem[a]);
      n++;
      if (a >= e || a == stop_byte) begin
        exp_q.push_back(8'h0d);
        exp_q.push_back(8'h0a);
        break;
      end
      if (n == BPL) begin
        exp_q.push_back(8'h0d);
        exp_q.push_back(8'h0a);
        n = 0;
      end
      a++;
    end
  endtask

  task automatic issue(input logic [7:0] s, input logic [7:0] e);
    @(negedge clk);
    tx_ready       = 1'b1;
    adr_dat        = s;
    read_start_set = 1'b1;
    @(negedge clk);
    read_start_set = 1'b0;
    adr_dat        = e;
    read_end_set   = 1'b1;
    checks++;
    if (dump_running !== 1'b0) begin
      errors++;
      $display("FAIL run_before_start: dump_running=%b expected 0", dump_running);
    end
  endtask

  task automatic run_dump(input logic [7:0] s, input logic [7:0] e, input bit bp,
                          input int stop_at, input int stop_byte, input int exp_ren,
                          input bit no_zero, input string name);
    int  ren;
    int  viol;
    int  zero_adr;
    int  bad;
    int  first_bad;
    bit  hold;
    bit  done;
    bit  last_lf;
    bit  stopped;
    logic [7:0] hold_data;
    ren = 0; viol = 0; zero_adr = 0; hold = 0; done = 0; last_lf = 0; stopped = 0;
    hold_data = 8'h00;
    got_q.delete();
    issue(s, e);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      read_end_set = 1'b0;
      if (c == 0) begin
        checks++;
        if (dump_running !== 1'b1) begin
          errors++;
          $display("FAIL %s run_rise: dump_running=%b expected 1", name, dump_running);
        end
      end
      if (!dump_running) begin
        done = 1;
        break;
      end
      tx_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      read_stop = (stop_at >= 0 && !stopped && got_q.size() == stop_at && tx_valid);
      if (read_stop) stopped = 1;
      if (hold && (!tx_valid || tx_data !== hold_data)) viol++;
      hold      = tx_valid & ~tx_ready;
      hold_data = tx_data;
      if (mem_ren) begin
        ren++;
        if (no_zero && mem_radr == 8'h00) zero_adr++;
      end
      last_lf = tx_valid && tx_ready && tx_data == 8'h0a;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
    end
    read_stop = 1'b0;
    tx_ready  = 1'b1;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: dump_running still high after cycle budget", name);
    end
    checks++;
    if (!last_lf) begin
      errors++;
      $display("FAIL %s run_fall: dump_running did not fall the cycle after LF", name);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL %s tx_stable: %0d hold violations, expected 0", name, viol);
    end
    checks++;
    if (ren != exp_ren) begin
      errors++;
      $display("FAIL %s mem_ren_count: got %0d expected %0d", name, ren, exp_ren);
    end
    checks++;
    if (zero_adr != 0) begin
      errors++;
      $display("FAIL %s adr_wrap: %0d reads at 0x00, expected 0", name, zero_adr);
    end
    build_exp(int'(s), int'(e), stop_byte);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s char_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s chars: %0d differ, first at %0d got %02h expected %02h",
               name, bad, first_bad, got_q[first_bad], exp_q[first_bad]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    adr_dat = 8'h00; read_start_set = 1'b0; read_end_set = 1'b0;
    read_stop = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    checks++;
    if ({dump_running, mem_ren, tx_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: running/ren/valid=%b expected 000",
               {dump_running, mem_ren, tx_valid});
    end
    checks++;
    if (mem_radr !== 8'h00 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: radr=%02h tx_data=%02h expected 00 00", mem_radr, tx_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dump_running !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: running=%b valid=%b expected 0 0", dump_running, tx_valid);
    end
  endtask

  task automatic test_basic_line();
    mem[0] = 8'h00; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
    run_dump(8'h00, 8'h03, 1'b0, -1, -1, 4, 1'b0, "basic_line");
  endtask

  task automatic test_two_lines();
    for (int i = 8'h10; i <= 8'h1f; i++) mem[i] = 8'(i);
    run_dump(8'h10, 8'h1f, 1'b0, -1, -1, 16, 1'b0, "two_lines");
  endtask

  task automatic test_end_below_start();
    mem[5] = 8'hab;
    run_dump(8'h05, 8'h02, 1'b0, -1, -1, 1, 1'b0, "end_below_start");
  endtask

  task automatic test_top_backpressure();
    mem[8'hfe] = 8'($urandom);
    mem[8'hff] = 8'($urandom);
    run_dump(8'hfe, 8'hff, 1'b1, -1, -1, 2, 1'b1, "top_backpressure");
  endtask

  task automatic test_random_range();
    int s;
    s = $urandom_range(0, 200);
    run_dump(8'(s), 8'(s + 20), 1'b1, -1, -1, 21, 1'b0, "random_range");
  endtask

  task automatic test_stop();
    for (int i = 0; i <= 8'h0a; i++) mem[i] = 8'(i);
    // 29 chars for line 0, then "08: 08 09 " = 10 more; char 39 is the DH of 0x0a.
    run_dump(8'h00, 8'hff, 1'b0, 39, 8'h0a, 11, 1'b0, "stop");
  endtask

  task automatic test_reset_mid_dump();
    issue(8'h40, 8'h7f);
    repeat (12) begin
      @(negedge clk);
      read_end_set = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dump_running, mem_ren, tx_valid} !== 3'b000 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_dump: running/ren/valid=%b tx_data=%02h expected 000 00",
               {dump_running, mem_ren, tx_valid}, tx_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 8'h20; i <= 8'h22; i++) mem[i] = 8'($urandom);
    run_dump(8'h20, 8'h22, 1'b0, -1, -1, 3, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_two_lines();
    test_end_below_start();
    test_top_backpressure();
    test_random_range();
    test_stop();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dump_engine.md
Name: dump_engine

Overview:
- Downstream consumer of the UART monitor's `r` command outputs: `read_start_set`, `read_end_set`, `read_stop` and `write_adr_dat`.
- Reads the byte memory from start to end address inclusive and formats the data as lowercase hex ASCII lines.
- Streams those characters to the UART transmitter over a valid/ready handshake.
- Drives `dump_running` back to the command controller so its dump state returns to idle when the dump completes.

Parameters:
BPL, 8, data bytes per output line (2..16)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
adr_dat  in  8  address byte from controller (write_adr_dat)
read_start_set  in  1  1-cycle pulse: latch adr_dat as start address
read_end_set  in  1  1-cycle pulse: latch adr_dat as end address, begin dump
read_stop  in  1  1-cycle pulse: abort dump
dump_running  out  1  high while a dump is in progress
mem_ren  out  1  memory read strobe
mem_radr  out  8  memory read address
mem_rdata  in  8  read data, valid exactly 1 cycle after mem_ren
tx_data  out  8  ASCII character to UART TX
tx_valid  out  1  character available
tx_ready  in  1  UART TX accepts; transfer on tx_valid & tx_ready

Behaviour:
- Reset values: dump_running=0, mem_ren=0, mem_radr=0, tx_valid=0, tx_data=0. Internal start/end/current address = 0; state=IDLE.
- Handshake rules:
  - Once tx_valid=1, tx_data stays stable and tx_valid stays high until the transfer cycle.
  - At most one character is transferred per cycle.
- Hex digits are 0-9 and a-f (lowercase only).
- Line format: "AA:" then, for each byte, " DD", then CR (0x0d) LF (0x0a).
  - AA is the address of the first byte on that line.
  - Example: "00: 12 34\r\n".
- States: IDLE, ADRH, ADRL, COLON, RDREQ, RDWAIT, SP, DH, DL, CR, LF.
- IDLE:
  - read_start_set latches start.
  - read_end_set latches end, sets cur=start and cnt=0, and moves to ADRH.
  - dump_running rises on the cycle after read_end_set.
- ADRH/ADRL/COLON: emit cur[7:4], cur[3:0], ':' in turn. Each state advances only on transfer.
- RDREQ: mem_ren=1 and mem_radr=cur for exactly one cycle, then RDWAIT.
- RDWAIT: capture mem_rdata into a data register, then SP.
- SP/DH/DL: emit ' ', data[7:4], data[3:0] in turn.
- After the DL transfer, first match wins:
  - stop pending, or cur==end → CR, then LF, then IDLE.
  - cnt==BPL-1 → CR, LF, then ADRH with cur+1 and cnt=0.
  - Otherwise → RDREQ with cur+1 and cnt+1.
- dump_running falls on the cycle after the final LF transfer.
- end < start: only the byte at start is dumped (one line), because cur==end is never met first. To guarantee this, compare with "cur==end or cur>=end" — i.e. terminate on cur>=end.
- end=0xff: terminates at 0xff; cur never wraps to 0x00.
- read_stop:
  - In IDLE: ignored.
  - While running: sets a sticky stop flag. The in-flight character completes and the current byte's remaining chars are emitted, then CR LF, then IDLE. The flag clears on entering IDLE.
  - If stop arrives during ADRH/ADRL/COLON: finish the address prefix, skip the read, go straight to CR LF.
- read_start_set/read_end_set while running: ignored (latched values unchanged).
- Simultaneous read_end_set and read_stop in IDLE: start is accepted and stop is ignored.
- Reset mid-dump: all outputs return to reset values immediately (async). No partial line is resumed.

Test Plan:
1. mem[0..3]=00,11,22,33; start=00, end=03, tx_ready=1 → stream "00: 00 11 22 33\r\n". dump_running high from the cycle after read_end_set until the cycle after LF.
2. start=0x10, end=0x1f, mem[i]=i, BPL=8 → two lines, "10: 10 11 ... 17\r\n" and "18: 18 ... 1f\r\n". Exactly 16 mem_ren pulses.
3. start=0x05, end=0x02, mem[5]=ab → "05: ab\r\n" only, then idle.
4. start=0xfe, end=0xff with random tx_ready backpressure (~50%) → "fe: xx yy\r\n". tx_data is stable whenever tx_valid & ~tx_ready. No mem_radr wrap to 0x00.
5. start=00, end=ff; read_stop pulsed during the DH of byte 0x0a → the line ends with " 0a"-data followed by CR LF, then IDLE. No further mem_ren; dump_running drops.
6. rst_n asserted mid-line → tx_valid, mem_ren and dump_running drop immediately. A new dump afterwards starts cleanly with the address prefix.
